// File: rtl/reg_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_writer
// Purpose  : Write side of a 4-entry register bank. Write requests
//            (destination index + data) enter through a valid/ready
//            handshake into a 2-entry in-order queue. At most one entry
//            retires per cycle into its destination register. A per-register
//            pending scoreboard and a registered one-hot write strobe are
//            provided for downstream logic.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - request handshake
//            in_dest, in_data    - request payload
//            drain_en            - allows the queue head to retire this cycle
//            q0..q3              - register contents
//            wr_strobe           - one-hot, high the cycle after a write
//            pending             - bit i set while a queued entry targets reg i
//            count               - queue occupancy 0..2
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_writer #(
   parameter int registerDataWidth = 16,
   parameter int QUEUE_DEPTH       = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   in_dest,
   input  logic [registerDataWidth-1:0] in_data,
   input  logic                         drain_en,
   output logic [registerDataWidth-1:0] q0,
   output logic [registerDataWidth-1:0] q1,
   output logic [registerDataWidth-1:0] q2,
   output logic [registerDataWidth-1:0] q3,
   output logic [3:0]                   wr_strobe,
   output logic [3:0]                   pending,
   output logic [1:0]                   count
);

   localparam logic [1:0] c_cnt_full = 2'(QUEUE_DEPTH);

   // Shift-style queue: slot 0 is always the head, slot 1 the tail when full.
   logic [1:0]                   r_slot_dest [0:1];
   logic [registerDataWidth-1:0] r_slot_data [0:1];
   logic [1:0]                   r_count;
   logic [registerDataWidth-1:0] r_regs [0:3];
   logic [3:0]                   r_wr_strobe;

   logic                         w_push;
   logic                         w_pop;
   logic [3:0]                   w_pending;

   assign in_ready = (r_count != c_cnt_full);
   assign w_push   = in_valid & in_ready;
   assign w_pop    = drain_en & (r_count != 2'd0);

   // Queue storage and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_slot_dest[i] <= 2'd0;
            r_slot_data[i] <= '0;
         end
      end else begin
         if (w_push && w_pop) begin
            // Only reachable with one entry queued: the new request
            // replaces the retiring head, occupancy is unchanged.
            r_slot_dest[0] <= in_dest;
            r_slot_data[0] <= in_data;
         end else if (w_pop) begin
            r_slot_dest[0] <= r_slot_dest[1];
            r_slot_data[0] <= r_slot_data[1];
            r_count        <= r_count - 2'd1;
         end else if (w_push) begin
            // Push without pop only happens with 0 or 1 entries, so the
            // low count bit is the free slot index.
            r_slot_dest[r_count[0]] <= in_dest;
            r_slot_data[r_count[0]] <= in_data;
            r_count                 <= r_count + 2'd1;
         end
      end
   end

   // Register bank and write strobe; the head is written on its pop edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_strobe <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_pop) begin
            r_regs[r_slot_dest[0]] <= r_slot_data[0];
            r_wr_strobe            <= 4'b0001 << r_slot_dest[0];
         end else begin
            r_wr_strobe <= 4'b0000;
         end
      end
   end

   // Pending scoreboard covers only entries already held in the queue.
   always_comb begin
      w_pending = 4'b0000;
      if (r_count != 2'd0) begin
         w_pending[r_slot_dest[0]] = 1'b1;
      end
      if (r_count == 2'd2) begin
         w_pending[r_slot_dest[1]] = 1'b1;
      end
   end

   assign pending   = w_pending;
   assign wr_strobe = r_wr_strobe;
   assign count     = r_count;
   assign q0        = r_regs[0];
   assign q1        = r_regs[1];
   assign q2        = r_regs[2];
   assign q3        = r_regs[3];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_writer
// Purpose  : Self-checking bench for reg_bank_writer. A queue-based model of
//            the request FIFO and register bank predicts every output; a
//            negedge compare process checks them each cycle, and directed
//            literal checks pin the model on known scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_writer;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_dest;
   logic [W-1:0]  in_data;
   logic          drain_en;
   logic [W-1:0]  q0, q1, q2, q3;
   logic [3:0]    wr_strobe;
   logic [3:0]    pending;
   logic [1:0]    count;

   always #5 clk = ~clk;

   reg_bank_writer #(.registerDataWidth(W), .QUEUE_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dest   (in_dest),
      .in_data   (in_data),
      .drain_en  (drain_en),
      .q0        (q0),
      .q1        (q1),
      .q2        (q2),
      .q3        (q3),
      .wr_strobe (wr_strobe),
      .pending   (pending),
      .count     (count)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [1:0]   dest;
      logic [W-1:0] data;
   } req_t;

   req_t         mq[$];
   logic [W-1:0] mregs [0:3] = '{default: '0};
   logic [3:0]   mstrb = 4'b0000;
   bit           m_acc, m_pop;
   req_t         m_head;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         for (int i = 0; i < 4; i++) mregs[i] = '0;
         mstrb = 4'b0000;
      end else begin
         m_acc = in_valid && (mq.size() != 2);
         m_pop = drain_en && (mq.size() != 0);
         mstrb = 4'b0000;
         if (m_pop) begin
            m_head = mq.pop_front();
            mregs[m_head.dest] = m_head.data;
            mstrb[m_head.dest] = 1'b1;
         end
         if (m_acc) mq.push_back('{dest: in_dest, data: in_data});
      end
   end

   function automatic logic [3:0] model_pending();
      logic [3:0] p = 4'b0000;
      foreach (mq[i]) p[mq[i].dest] = 1'b1;
      return p;
   endfunction

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("q0", 32'(q0), 32'(mregs[0]));
         chk("q1", 32'(q1), 32'(mregs[1]));
         chk("q2", 32'(q2), 32'(mregs[2]));
         chk("q3", 32'(q3), 32'(mregs[3]));
         chk("wr_strobe", 32'(wr_strobe), 32'(mstrb));
         chk("pending", 32'(pending), 32'(model_pending()));
         chk("count", 32'(count), 32'(mq.size()));
         chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   int         sent;
   bit         acc;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_dest  = 2'd0;
      in_data  = '0;
      drain_en = 1'b0;
      cyc();
      cmp_en = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();

      // Reset then idle
      at_neg();
      chk("idle_q0", 32'(q0), 32'h0);
      chk("idle_q3", 32'(q3), 32'h0);
      chk("idle_count", 32'(count), 32'h0);
      chk("idle_ready", 32'(in_ready), 32'h1);
      chk("idle_pending", 32'(pending), 32'h0);
      chk("idle_strobe", 32'(wr_strobe), 32'h0);

      // Single write, dest 2
      #1;
      drain_en = 1'b1;
      in_valid = 1'b1; in_dest = 2'd2; in_data = 16'h1234;
      cyc();
      in_valid = 1'b0;
      at_neg();
      chk("single_pending", 32'(pending), 32'b0100);
      chk("single_q2_before", 32'(q2), 32'h0);
      cyc();
      at_neg();
      chk("single_q2", 32'(q2), 32'h1234);
      chk("single_strobe", 32'(wr_strobe), 32'b0100);
      chk("single_pending_drop", 32'(pending), 32'h0);
      cyc();
      at_neg();
      chk("single_strobe_off", 32'(wr_strobe), 32'h0);

      // Back-to-back writes
      #1;
      in_valid = 1'b1; in_dest = 2'd0; in_data = 16'hAAAA;
      cyc();
      in_dest = 2'd3; in_data = 16'h5555;
      cyc();
      in_valid = 1'b0;
      at_neg();
      chk("b2b_q0", 32'(q0), 32'hAAAA);
      chk("b2b_strobe0", 32'(wr_strobe), 32'b0001);
      chk("b2b_count", 32'(count), 32'h1);
      cyc();
      at_neg();
      chk("b2b_q3", 32'(q3), 32'h5555);
      chk("b2b_strobe3", 32'(wr_strobe), 32'b1000);

      // Backpressure
      #1;
      drain_en = 1'b0;
      in_valid = 1'b1; in_dest = 2'd1; in_data = 16'h0001;
      cyc();
      in_data = 16'h0002;
      cyc();
      in_dest = 2'd2; in_data = 16'hBEEF;   // held third request
      at_neg();
      chk("bp_count", 32'(count), 32'h2);
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_pending", 32'(pending), 32'b0010);
      cyc(); cyc();
      at_neg();
      chk("bp_hold_count", 32'(count), 32'h2);
      chk("bp_hold_q1", 32'(q1), 32'h0);
      #1;
      drain_en = 1'b1;
      cyc();
      at_neg();
      chk("bp_q1_first", 32'(q1), 32'h0001);
      chk("bp_count_after_pop", 32'(count), 32'h1);
      cyc();
      in_valid = 1'b0;
      at_neg();
      chk("bp_q1_second", 32'(q1), 32'h0002);
      chk("bp_held_pending", 32'(pending), 32'b0100);
      cyc();
      at_neg();
      chk("bp_held_written", 32'(q2), 32'hBEEF);

      // Random scoreboard run: 200 requests, random drain_en
      #1;
      sent     = 0;
      in_valid = 1'b0;
      while (sent < 200) begin
         if (!in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_dest  = 2'($urandom_range(0, 3));
            in_data  = W'($urandom);
         end
         drain_en = ($urandom_range(0, 9) < 7);
         acc = in_valid && (mq.size() != 2);
         cyc();
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      drain_en = 1'b1;
      repeat (4) cyc();
      at_neg();
      chk("rand_drained", 32'(count), 32'h0);

      // Reset mid-operation with a full queue
      #1;
      drain_en = 1'b0;
      in_valid = 1'b1; in_dest = 2'd0; in_data = 16'h1111;
      cyc();
      in_dest = 2'd3; in_data = 16'h2222;
      cyc();
      in_valid = 1'b0;
      drain_en = 1'b1;
      rst      = 1'b1;
      cyc();
      rst = 1'b0;
      at_neg();
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_q0", 32'(q0), 32'h0);
      chk("rst_q1", 32'(q1), 32'h0);
      chk("rst_q2", 32'(q2), 32'h0);
      chk("rst_q3", 32'(q3), 32'h0);
      chk("rst_strobe", 32'(wr_strobe), 32'h0);
      repeat (3) cyc();
      at_neg();
      chk("rst_no_late_q0", 32'(q0), 32'h0);
      chk("rst_no_late_q3", 32'(q3), 32'h0);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
